// File: rtl/m_memarb.sv
// m_memarb: round-robin arbiter sharing one single-port memory between an
// instruction-fetch port (0, read-only) and a load/store port (1, read/write).
module m_memarb #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_req0,
  input  logic [AW-1:0] w_addr0,
  input  logic          w_req1,
  input  logic          w_we1,
  input  logic [AW-1:0] w_addr1,
  input  logic [DW-1:0] w_wdata1,
  output logic          w_ack0,
  output logic          w_ack1,
  output logic [DW-1:0] w_rdata,
  output logic          w_busy,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic [CW-1:0] w_cnt0,
  output logic [CW-1:0] w_cnt1
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic          sel_reg, last_reg, we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg, rdata_reg;
  logic [1:0]    req_vec, elig, ack_vec;
  logic [CW-1:0] cnt_vec [2];
  logic          grant_valid, grant_port;

  assign req_vec = {w_req1, w_req0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic          served;
      logic          ack_reg;
      logic [CW-1:0] cnt_reg;

      // The port in its BUSY cycle still shows its in-flight request; ignore it.
      assign served   = (state_reg == BUSY) && (sel_reg == 1'(gi));
      assign elig[gi] = req_vec[gi] & ~served;

      always_ff @(posedge w_clk) begin
        if (w_rst) begin
          ack_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          ack_reg <= served;
          if (served) cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign ack_vec[gi] = ack_reg;
      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant_valid = |elig;
    grant_port  = (&elig) ? ~last_reg : elig[1];
  end

  always_comb begin
    state_next = grant_valid ? BUSY : IDLE;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sel_reg   <= 1'b0;
      last_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if ((state_reg == BUSY) && !we_reg) rdata_reg <= w_mdout;
      if (grant_valid) begin
        sel_reg   <= grant_port;
        last_reg  <= grant_port;
        we_reg    <= grant_port & w_we1;
        addr_reg  <= grant_port ? w_addr1 : w_addr0;
        wdata_reg <= grant_port ? w_wdata1 : '0;
      end
    end
  end

  // Reset mid-access must not let a write reach the memory.
  always_comb begin
    w_busy  = (state_reg == BUSY);
    w_maddr = addr_reg;
    w_mdin  = wdata_reg;
    w_mwe   = (state_reg == BUSY) & we_reg & ~w_rst;
  end

  assign w_ack0  = ack_vec[0];
  assign w_ack1  = ack_vec[1];
  assign w_rdata = rdata_reg;
  assign w_cnt0  = cnt_vec[0];
  assign w_cnt1  = cnt_vec[1];

endmodule

// File: doc/m_memarb.md
# m_memarb

Two-port arbiter that shares one single-port 4K-word m_amemory between an instruction-fetch requester (port 0, read-only) and a load/store requester (port 1, read/write) for the unified-memory multicycle processor. It registers the granted request and drives the shared memory address, write-enable and write-data. It captures the memory read data and returns it with a one-cycle ack pulse. Round-robin on conflict; per-port grant counters for performance inspection.

## Interface
Parameters:
- AW, 12, memory word-address width (matches m_amemory)
- DW, 32, data width
- CW, 16, grant-counter width

Ports:
- w_clk  in  1  clock, rising edge
- w_rst  in  1  synchronous, active-high reset
- w_req0  in  1  port 0 read request; held high until w_ack0
- w_addr0  in  AW  port 0 word address
- w_req1  in  1  port 1 request; held high until w_ack1
- w_we1  in  1  port 1 write (1) / read (0)
- w_addr1  in  AW  port 1 word address
- w_wdata1  in  DW  port 1 write data
- w_ack0  out  1  one-cycle pulse: port 0 access complete, w_rdata valid
- w_ack1  out  1  one-cycle pulse: port 1 access complete (w_rdata valid if read)
- w_rdata  out  DW  captured read data, shared by both ports
- w_busy  out  1  1 while in BUSY state
- w_maddr  out  AW  to m_amemory w_addr
- w_mwe  out  1  to m_amemory w_we
- w_mdin  out  DW  to m_amemory w_din
- w_mdout  in  DW  from m_amemory w_dout
- w_cnt0, w_cnt1  out  CW  number of completed grants per port

## Operation
- State: IDLE, BUSY. Registers: r_sel (port served), r_addr, r_we, r_wdata, r_last (last port granted).
- Grant decision at each rising edge from eligible requests. A port is eligible if its req is high and it is not the port being served in the current BUSY cycle. Its req there is the stale, in-flight request and is ignored.
- One eligible port: grant it. Both eligible: grant port != r_last.
- On grant: r_sel, r_addr, r_we (0 for port 0), r_wdata latched from the granted port; r_last <= granted port; next state BUSY.
- No eligible port: next state IDLE.
- BUSY cycle drives w_maddr=r_addr, w_mdin=r_wdata, w_mwe=r_we & ~w_rst. Memory write occurs at the edge ending the BUSY cycle.
- Edge ending BUSY:
  - w_rdata <= w_mdout (reads only; unchanged on writes).
  - w_ack[r_sel] <= 1.
  - w_cnt[r_sel] += 1, wrapping modulo 2^CW.
  - Grant decision applies as above. The other port may be granted immediately, giving back-to-back BUSY cycles.
- IDLE: w_maddr=r_addr (held), w_mwe=0.
- Requester rule: deassert req, or present its next request, during its ack cycle. The req sampled at the edge ending the ack cycle is treated as a new request.

## Timing
- Reset (edge with w_rst=1) sets:
  - state IDLE; w_ack0=w_ack1=0; w_busy=0.
  - w_rdata=0; w_cnt0=w_cnt1=0.
  - r_addr=0, r_we=0, r_wdata=0.
  - r_last=0, so the first tie goes to port 1 (data).
- Reset asserted during a BUSY write suppresses w_mwe that cycle; memory is not written. No ack is issued for an aborted access.
- Latency: req high at edge E0 (state IDLE) -> BUSY in cycle after E0 -> ack high in the following cycle (ack 2 edges after E0). w_rdata is valid in the ack cycle and holds until the next read completes.
- Single-port throughput: one access per 2 cycles. Alternating ports: one access per cycle.
- Memory combinational read (20 ns) must settle within the BUSY cycle (100 ns period).
- w_ack0 and w_ack1 are never high in the same cycle.

## Test plan
- Reset, then req0 with addr0=5 (mem[5]=0x1234) -> w_busy=1 for 1 cycle, then w_ack0=1 for exactly 1 cycle with w_rdata=0x1234; w_cnt0=1.
- Port 1 write, addr1=32, wdata1=0x55; then port 1 read, addr 32 -> write ack with w_mwe high for exactly one cycle. Read ack 2 cycles after the new req returns w_rdata=0x55.
- Both reqs rise together after reset (addr0=0, addr1=1, mem[0]=0x222, mem[1]=0x333):
  - port 1 is granted first: w_ack1 with 0x333;
  - w_ack0 follows in the next cycle with 0x222;
  - BUSY for two consecutive cycles.
- Both reqs held continuously for 8 accesses -> grants strictly alternate, w_cnt0=w_cnt1=4. Each port keeps one access in flight and presents its next request in its ack cycle.
- req1 write in flight, w_rst pulsed during the BUSY cycle -> target word unchanged, no ack, all outputs at reset values next cycle.
- Preload w_cnt0=0xFFFF (force) and complete one port 0 read -> w_cnt0 wraps to 0x0000.
